// File: rtl/mem_write_buffer.sv
// Posted-store buffer: queues CPU stores in a FIFO and drains them to memory via req/ack.
// Optional macro WBUF_TIMEOUT_EN adds a 255-cycle ack timeout that drops the head and sets err.
module mem_write_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       mem_wr_req,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [DATA_W-1:0]          mem_wr_data,
    input  logic                       mem_wr_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              timeout_hit;
    logic [CW-1:0]     count_next;

    assign st_ready    = (count != CW'(DEPTH));
    assign push        = st_valid && st_ready;
    assign pop         = (state == REQ) && (mem_wr_ack || timeout_hit);
    assign mem_wr_addr = addr_q[rd_ptr];
    assign mem_wr_data = data_q[rd_ptr];
    assign empty       = (count == '0) && (state == IDLE);

    always_comb begin
        count_next = count;
        if (push && !pop) count_next = count + CW'(1);
        else if (pop && !push) count_next = count - CW'(1);
    end

    // Storage and pointers; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= st_addr;
                data_q[wr_ptr] <= st_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_wr_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state      <= REQ;
                        mem_wr_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (pop && count_next == '0) begin
                        state      <= IDLE;
                        mem_wr_req <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_wr_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef WBUF_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // A same-cycle ack wins over the timeout, so it is a normal pop with no error
    assign timeout_hit = (state == REQ) && (wait_cnt == 8'hFF) && !mem_wr_ack;
    assign err         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE) wait_cnt <= '0;
            else if (pop) wait_cnt <= '0;
            else wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: handshake, fill/drain, streaming, async reset, timeout.
module tb_mem_write_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [7:0]  st_addr = '0;
    logic [15:0] st_data = '0;
    logic        mem_wr_req;
    logic [7:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_ack = 1'b0;
    logic        empty;
    logic [2:0]  count;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] obs_q [$];
    int          obs_cyc [$];
    logic [23:0] exp_q [$];

    mem_write_buffer #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .mem_wr_req (mem_wr_req),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_ack (mem_wr_ack),
        .empty      (empty),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && mem_wr_req && mem_wr_ack) begin
            obs_q.push_back({mem_wr_addr, mem_wr_data});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_n"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), obs_cyc[i] - obs_cyc[i-1], 1);
        end
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        check("rst_req", mem_wr_req, 0);
        check("rst_addr", mem_wr_addr, 0);
        check("rst_data", mem_wr_data, 0);
        check("rst_ready", st_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single store
        st_valid = 1; st_addr = 8'h12; st_data = 16'hBEEF;
        step();
        st_valid = 0;
        check("s_cnt1", count, 1);
        check("s_req_n", mem_wr_req, 0);
        check("s_empty0", empty, 0);
        step();
        check("s_req_n1", mem_wr_req, 1);
        check("s_addr", mem_wr_addr, 8'h12);
        check("s_data", mem_wr_data, 16'hBEEF);
        step();
        check("s_req_hold", mem_wr_req, 1);
        check("s_addr_hold", mem_wr_addr, 8'h12);
        mem_wr_ack = 1;
        step();
        mem_wr_ack = 0;
        check("s_cnt0", count, 0);
        check("s_req_off", mem_wr_req, 0);
        check("s_empty", empty, 1);

        // Fill with ack low, then drain
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        for (int i = 1; i <= 4; i++) begin
            st_valid = 1; st_addr = 8'(i); st_data = 16'(i * 16'h1111);
            exp_q.push_back({8'(i), 16'(i * 16'h1111)});
            step();
        end
        check("f_ready", st_ready, 0);
        check("f_cnt4", count, 4);
        st_addr = 8'h05; st_data = 16'h5555;
        step();
        st_valid = 0;
        check("f_cnt_still4", count, 4);
        check("f_head", mem_wr_addr, 8'h01);
        mem_wr_ack = 1;
        repeat (4) step();
        mem_wr_ack = 0;
        check("f_cnt0", count, 0);
        check("f_req_off", mem_wr_req, 0);
        step();
        check_stream("fill");
        check("f_empty", empty, 1);

        // Concurrent push/pop at count = 2
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            st_valid = 1; st_addr = 8'h30 + 8'(i); st_data = 16'hC000 + 16'(i);
            exp_q.push_back({8'h30 + 8'(i), 16'hC000 + 16'(i)});
            step();
        end
        st_valid = 0;
        step();
        check("c_req", mem_wr_req, 1);
        mem_wr_ack = 1;
        for (int i = 2; i < 8; i++) begin
            st_valid = 1; st_addr = 8'h30 + 8'(i); st_data = 16'hC000 + 16'(i);
            exp_q.push_back({8'h30 + 8'(i), 16'hC000 + 16'(i)});
            step();
            check($sformatf("c_cnt%0d", i), count, 2);
        end
        st_valid = 0;
        repeat (2) step();
        mem_wr_ack = 0;
        check("c_cnt0", count, 0);
        step();
        check_stream("conc");
        check("c_empty", empty, 1);

        // Asynchronous reset with stores queued
        for (int i = 0; i < 3; i++) begin
            st_valid = 1; st_addr = 8'h40 + 8'(i); st_data = 16'hD000 + 16'(i);
            step();
        end
        st_valid = 0;
        check("r_req_pre", mem_wr_req, 1);
        check("r_cnt_pre", count, 3);
        #2;
        rst_n = 0;
        #1;
        check("r_req", mem_wr_req, 0);
        check("r_cnt", count, 0);
        check("r_ready", st_ready, 1);
        check("r_empty", empty, 1);
        check("r_addr", mem_wr_addr, 0);
        @(negedge clk);
        rst_n = 1;
        obs_q.delete(); obs_cyc.delete();
        mem_wr_ack = 1;
        repeat (5) step();
        mem_wr_ack = 0;
        check("r_nowrites", obs_q.size(), 0);
        check("r_req_after", mem_wr_req, 0);

        // Timeout behaviour
        st_valid = 1; st_addr = 8'h20; st_data = 16'hAAAA;
        step();
        st_addr = 8'h21; st_data = 16'hBBBB;
        step();
        st_valid = 0;
`ifdef WBUF_TIMEOUT_EN
        n = 0;
        while (!err && n < 400) begin
            step();
            n++;
        end
        check("t_err_set", err, 1);
        check("t_head_addr", mem_wr_addr, 8'h21);
        check("t_head_data", mem_wr_data, 16'hBBBB);
        check("t_cnt1", count, 1);
        mem_wr_ack = 1;
        step();
        mem_wr_ack = 0;
        step();
        check("t_empty", empty, 1);
        check("t_err_sticky", err, 1);
`else
        n = 0;
        while (mem_wr_req && n < 300) begin
            step();
            n++;
        end
        check("t_wait_cycles", n, 300);
        check("t_req_hold", mem_wr_req, 1);
        check("t_err0", err, 0);
        check("t_head_addr", mem_wr_addr, 8'h20);
        check("t_head_data", mem_wr_data, 16'hAAAA);
        check("t_cnt2", count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-store buffer between the CPU datapath and data memory, the write-side counterpart to the DR read-capture register. Accepts 16-bit store requests (address + data) from the control unit through a valid/ready handshake. Queues them in a small FIFO and drains them to memory with a req/ack protocol, so stores do not stall the CPU while memory is busy.

## Interface
Parameters:
- DATA_W, 16, store data width
- ADDR_W, 8, memory address width
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  CPU presents a store
- st_ready  out  1  buffer can accept a store (= !full)
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- mem_wr_req  out  1  write request to memory
- mem_wr_addr  out  ADDR_W  address of the head entry
- mem_wr_data  out  DATA_W  data of the head entry
- mem_wr_ack  in  1  memory has completed the write this cycle
- empty  out  1  FIFO empty and no write outstanding
- count  out  $clog2(DEPTH)+1  occupied entries
- err  out  1  sticky timeout flag (see Configuration)

## Operation
- Push: on a rising edge with st_valid && st_ready, {st_addr, st_data} is written at the tail and count increments.
- st_ready = (count != DEPTH), combinational from registered count. There is no pass-through when full, even if a pop occurs in the same cycle.
- mem_wr_addr/mem_wr_data = head entry, driven combinationally from storage. The head only changes on pop, so both are stable while mem_wr_req is high.
- FSM, two states:
  - IDLE: mem_wr_req = 0. Go to REQ when count != 0.
  - REQ: mem_wr_req = 1. On an edge where mem_wr_ack = 1, the head is popped. If the post-edge count is 0, go to IDLE; otherwise stay in REQ and present the next entry back-to-back.
- mem_wr_ack is ignored in IDLE.
- Simultaneous push and pop: both occur and count is unchanged. Pointers wrap modulo DEPTH.
- empty = (count == 0) && (state == IDLE).
- Stores drain strictly in order. There is no merging or forwarding.

## Timing
- Reset (async assert, sync release on clk): state = IDLE, count = 0, pointers = 0, all storage = 0, err = 0.
- Reset output values: mem_wr_req = 0, mem_wr_addr = 0, mem_wr_data = 0, st_ready = 1, empty = 1.
- Latency: a store pushed at edge N raises mem_wr_req after edge N+1 (FIFO previously empty). Earliest pop is at edge N+2 if ack is high in that cycle.
- Throughput: one store per cycle in each direction when ack is held high.
- mem_wr_req is registered (FSM state). It deasserts after the acking edge only if the FIFO becomes empty.
- If reset is asserted mid-request, mem_wr_req drops immediately and all queued stores are discarded.

## Configuration
- Macro WBUF_TIMEOUT_EN.
  - Defined: an 8-bit wait counter clears on entering REQ and on every pop, and increments each REQ cycle without ack. When it reaches 255, the head entry is dropped (popped as if acked) and err is set. err stays set until reset. Any ack arriving in that same cycle is treated as a normal pop.
  - Undefined: no counter exists, err is tied 0, and REQ waits indefinitely.

## Test plan
- Single store: push addr 0x12 data 0xBEEF; ack 2 cycles after req rises -> req high from edge N+1, addr/data = 0x12/0xBEEF while req is high, count returns to 0, empty = 1.
- Fill: push 4 stores (0x01..0x04 / 0x1111..0x4444) with ack held low -> st_ready = 0 after the 4th push and a 5th st_valid is not accepted. Then hold ack high -> four writes drain in order on consecutive cycles.
- Concurrent push/pop: with count = 2 and ack high, push every cycle for 6 cycles -> count stays 2 and memory sees all stores in order with no gaps.
- Reset mid-operation: 3 queued stores, req high; pull rst_n low asynchronously -> req = 0, count = 0, st_ready = 1 within the same cycle, and no further writes after release.
- Timeout (WBUF_TIMEOUT_EN): push 0x20/0xAAAA and 0x21/0xBBBB, never ack the first -> after 255 REQ cycles err = 1 and head becomes 0x21/0xBBBB. Ack it -> empty = 1, err remains 1. Without the macro, req stays high and err = 0.
